// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master
// Single-outstanding AXI4-Lite initiator. A command port issues one register
// write or read at a time. The block drives AW/W/B or AR/R and returns exactly
// one response per command. A per-transaction timeout aborts a stalled
// transfer so that a hung slave cannot block the issuer.
// Every output, including cmd_ready, comes straight from a flop.

module axi_lite_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,

    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,

    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,

    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,

    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,

    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 32'sd0);
    localparam int CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 32'sd1) : 1;

    // The last cycle of the budget, and the saturation ceiling of the counter.
    localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 32'sd1) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES)          : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [CNT_W-1:0]        cnt_r;

    // Registered outputs and their next-state values.
    logic                    cmd_ready_r,   cmd_ready_nxt_s;
    logic                    rsp_valid_r,   rsp_valid_nxt_s;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r,   rsp_rdata_nxt_s;
    logic [1:0]              rsp_resp_r,    rsp_resp_nxt_s;
    logic                    rsp_timeout_r, rsp_timeout_nxt_s;
    logic [ADDR_WIDTH-1:0]   awaddr_r,      awaddr_nxt_s;
    logic                    awvalid_r,     awvalid_nxt_s;
    logic [DATA_WIDTH-1:0]   wdata_r,       wdata_nxt_s;
    logic [STRB_WIDTH-1:0]   wstrb_r,       wstrb_nxt_s;
    logic                    wvalid_r,      wvalid_nxt_s;
    logic                    bready_r,      bready_nxt_s;
    logic [ADDR_WIDTH-1:0]   araddr_r,      araddr_nxt_s;
    logic                    arvalid_r,     arvalid_nxt_s;
    logic                    rready_r,      rready_nxt_s;

    // Handshake and timing qualifiers.
    logic                    accept_s;
    logic                    aw_done_s;
    logic                    w_done_s;
    logic                    wr_req_done_s;
    logic                    ar_hs_s;
    logic                    b_hs_s;
    logic                    r_hs_s;
    logic                    rsp_hs_s;
    logic                    expire_s;
    logic                    busy_s;
    logic                    phase_done_s;
    logic                    abort_s;

    assign accept_s      = (state_r == ST_IDLE) && cmd_valid && cmd_ready_r;
    // A write channel counts as done once its valid has dropped, or when it handshakes now.
    assign aw_done_s     = !awvalid_r || M_AXI_AWREADY;
    assign w_done_s      = !wvalid_r  || M_AXI_WREADY;
    assign wr_req_done_s = aw_done_s && w_done_s;
    assign ar_hs_s       = arvalid_r && M_AXI_ARREADY;
    assign b_hs_s        = bready_r  && M_AXI_BVALID;
    assign r_hs_s        = rready_r  && M_AXI_RVALID;
    assign rsp_hs_s      = rsp_valid_r && rsp_ready;
    // The counter saturates, so any later phase whose handshake is still missing also expires.
    // This covers a phase that entered on the expiry edge.
    assign expire_s      = TIMEOUT_EN && (cnt_r >= CNT_LAST);
    assign abort_s       = busy_s && !phase_done_s && expire_s;

    // Classify the current state: is a bus phase active, and does it complete on this edge.
    always_comb begin
        busy_s       = 1'b0;
        phase_done_s = 1'b0;
        case (state_r)
            ST_WR_REQ: begin
                busy_s       = 1'b1;
                phase_done_s = wr_req_done_s;
            end
            ST_WR_RESP: begin
                busy_s       = 1'b1;
                phase_done_s = b_hs_s;
            end
            ST_RD_REQ: begin
                busy_s       = 1'b1;
                phase_done_s = ar_hs_s;
            end
            ST_RD_RESP: begin
                busy_s       = 1'b1;
                phase_done_s = r_hs_s;
            end
            default: begin
                busy_s       = 1'b0;
                phase_done_s = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic. A handshake that completes on the expiry edge takes priority over the timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = cmd_write ? ST_WR_REQ : ST_RD_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                if (wr_req_done_s) begin
                    state_nxt_s = ST_WR_RESP;
                end else if (expire_s) begin
                    state_nxt_s = ST_RSP;
                end else begin
                    state_nxt_s = ST_WR_REQ;
                end
            end
            ST_WR_RESP: begin
                if (b_hs_s || expire_s) begin
                    state_nxt_s = ST_RSP;
                end else begin
                    state_nxt_s = ST_WR_RESP;
                end
            end
            ST_RD_REQ: begin
                if (ar_hs_s) begin
                    state_nxt_s = ST_RD_RESP;
                end else if (expire_s) begin
                    state_nxt_s = ST_RSP;
                end else begin
                    state_nxt_s = ST_RD_REQ;
                end
            end
            ST_RD_RESP: begin
                if (r_hs_s || expire_s) begin
                    state_nxt_s = ST_RSP;
                end else begin
                    state_nxt_s = ST_RD_RESP;
                end
            end
            ST_RSP: begin
                if (rsp_hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RSP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values of every registered output, decided from the current state and inputs.
    always_comb begin
        cmd_ready_nxt_s   = cmd_ready_r;
        rsp_valid_nxt_s   = rsp_valid_r;
        rsp_rdata_nxt_s   = rsp_rdata_r;
        rsp_resp_nxt_s    = rsp_resp_r;
        rsp_timeout_nxt_s = rsp_timeout_r;
        awaddr_nxt_s      = awaddr_r;
        awvalid_nxt_s     = awvalid_r;
        wdata_nxt_s       = wdata_r;
        wstrb_nxt_s       = wstrb_r;
        wvalid_nxt_s      = wvalid_r;
        bready_nxt_s      = bready_r;
        araddr_nxt_s      = araddr_r;
        arvalid_nxt_s     = arvalid_r;
        rready_nxt_s      = rready_r;
        if (abort_s) begin
            awvalid_nxt_s     = 1'b0;
            wvalid_nxt_s      = 1'b0;
            bready_nxt_s      = 1'b0;
            arvalid_nxt_s     = 1'b0;
            rready_nxt_s      = 1'b0;
            rsp_valid_nxt_s   = 1'b1;
            rsp_rdata_nxt_s   = {DATA_WIDTH{1'b0}};
            rsp_resp_nxt_s    = RESP_SLVERR;
            rsp_timeout_nxt_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cmd_ready_nxt_s = 1'b0;
                        awaddr_nxt_s    = cmd_addr;
                        araddr_nxt_s    = cmd_addr;
                        wdata_nxt_s     = cmd_wdata;
                        wstrb_nxt_s     = cmd_wstrb;
                        awvalid_nxt_s   = cmd_write;
                        wvalid_nxt_s    = cmd_write;
                        arvalid_nxt_s   = !cmd_write;
                    end else begin
                        cmd_ready_nxt_s = 1'b1;
                    end
                end
                ST_WR_REQ: begin
                    awvalid_nxt_s = awvalid_r && !M_AXI_AWREADY;
                    wvalid_nxt_s  = wvalid_r  && !M_AXI_WREADY;
                    if (wr_req_done_s) begin
                        bready_nxt_s = 1'b1;
                    end else begin
                        bready_nxt_s = 1'b0;
                    end
                end
                ST_WR_RESP: begin
                    if (b_hs_s) begin
                        bready_nxt_s      = 1'b0;
                        rsp_valid_nxt_s   = 1'b1;
                        rsp_rdata_nxt_s   = {DATA_WIDTH{1'b0}};
                        rsp_resp_nxt_s    = M_AXI_BRESP;
                        rsp_timeout_nxt_s = 1'b0;
                    end else begin
                        bready_nxt_s = 1'b1;
                    end
                end
                ST_RD_REQ: begin
                    if (ar_hs_s) begin
                        arvalid_nxt_s = 1'b0;
                        rready_nxt_s  = 1'b1;
                    end else begin
                        arvalid_nxt_s = 1'b1;
                    end
                end
                ST_RD_RESP: begin
                    if (r_hs_s) begin
                        rready_nxt_s      = 1'b0;
                        rsp_valid_nxt_s   = 1'b1;
                        rsp_rdata_nxt_s   = M_AXI_RDATA;
                        rsp_resp_nxt_s    = M_AXI_RRESP;
                        rsp_timeout_nxt_s = 1'b0;
                    end else begin
                        rready_nxt_s = 1'b1;
                    end
                end
                ST_RSP: begin
                    if (rsp_hs_s) begin
                        rsp_valid_nxt_s = 1'b0;
                        cmd_ready_nxt_s = 1'b1;
                    end else begin
                        rsp_valid_nxt_s = 1'b1;
                    end
                end
                default: begin
                    cmd_ready_nxt_s = 1'b0;
                    rsp_valid_nxt_s = 1'b0;
                    awvalid_nxt_s   = 1'b0;
                    wvalid_nxt_s    = 1'b0;
                    bready_nxt_s    = 1'b0;
                    arvalid_nxt_s   = 1'b0;
                    rready_nxt_s    = 1'b0;
                end
            endcase
        end
    end

    // Output registers. Reset clears them asynchronously, which abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready_r   <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
            rsp_resp_r    <= 2'b00;
            rsp_timeout_r <= 1'b0;
            awaddr_r      <= {ADDR_WIDTH{1'b0}};
            awvalid_r     <= 1'b0;
            wdata_r       <= {DATA_WIDTH{1'b0}};
            wstrb_r       <= {STRB_WIDTH{1'b0}};
            wvalid_r      <= 1'b0;
            bready_r      <= 1'b0;
            araddr_r      <= {ADDR_WIDTH{1'b0}};
            arvalid_r     <= 1'b0;
            rready_r      <= 1'b0;
        end else begin
            cmd_ready_r   <= cmd_ready_nxt_s;
            rsp_valid_r   <= rsp_valid_nxt_s;
            rsp_rdata_r   <= rsp_rdata_nxt_s;
            rsp_resp_r    <= rsp_resp_nxt_s;
            rsp_timeout_r <= rsp_timeout_nxt_s;
            awaddr_r      <= awaddr_nxt_s;
            awvalid_r     <= awvalid_nxt_s;
            wdata_r       <= wdata_nxt_s;
            wstrb_r       <= wstrb_nxt_s;
            wvalid_r      <= wvalid_nxt_s;
            bready_r      <= bready_nxt_s;
            araddr_r      <= araddr_nxt_s;
            arvalid_r     <= arvalid_nxt_s;
            rready_r      <= rready_nxt_s;
        end
    end

    // Per-transaction cycle counter. It clears while idle, counts during bus phases and saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_IDLE) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (busy_s && (cnt_r < CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cmd_ready     = cmd_ready_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_rdata     = rsp_rdata_r;
    assign rsp_resp      = rsp_resp_r;
    assign rsp_timeout   = rsp_timeout_r;
    assign M_AXI_AWADDR  = awaddr_r;
    assign M_AXI_AWVALID = awvalid_r;
    assign M_AXI_WDATA   = wdata_r;
    assign M_AXI_WSTRB   = wstrb_r;
    assign M_AXI_WVALID  = wvalid_r;
    assign M_AXI_BREADY  = bready_r;
    assign M_AXI_ARADDR  = araddr_r;
    assign M_AXI_ARVALID = arvalid_r;
    assign M_AXI_RREADY  = rready_r;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master (TIMEOUT_CYCLES = 16).
// The stimulus runs in one initial block. The slave is driven by hand, and
// every expected value is written out in the sequence below.

module tb_axi_lite_cmd_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int errors = 0;
    int checks = 0;

    axi_lite_cmd_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle just after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic slave_idle;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 2'b00;
        arready = 1'b0;
        rvalid  = 1'b0;
        rresp   = 2'b00;
        rdata   = 32'h0;
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
    endtask

    // Consume the pending response, then expect cmd_ready back on the next cycle.
    task automatic consume(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk1({tag, "_rsp_valid_clear"}, rsp_valid, 1'b0);
        chk1({tag, "_cmd_ready_back"}, cmd_ready, 1'b1);
    endtask

    // Safety net in case the sequence below stalls.
    initial begin
        #100000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        cmd_wstrb = 4'h0;
        rsp_ready = 1'b0;
        slave_idle();

        // ---- reset state ----
        tick();
        tick();
        chk1("rst_cmd_ready", cmd_ready, 1'b0);
        chk1("rst_awvalid", awvalid, 1'b0);
        chk1("rst_arvalid", arvalid, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk32("rst_awaddr", awaddr, 32'h0);
        rst = 1'b0;
        #1;
        chk1("rel_cmd_ready_low", cmd_ready, 1'b0);
        tick();
        chk1("rel_cmd_ready_high", cmd_ready, 1'b1);

        // ---- write 0x0 = DEADBEEF, zero-wait slave ----
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        issue(1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF);
        tick();                                         // cycle 1
        cmd_valid = 1'b0;
        chk1("w1_awvalid", awvalid, 1'b1);
        chk1("w1_wvalid", wvalid, 1'b1);
        chk1("w1_cmd_ready", cmd_ready, 1'b0);
        chk1("w1_bready_c1", bready, 1'b0);
        chk32("w1_wdata", wdata, 32'hDEAD_BEEF);
        chk32("w1_wstrb", 32'(wstrb), 32'hF);
        tick();                                         // cycle 2
        chk1("w1_bready_c2", bready, 1'b1);
        chk1("w1_awvalid_c2", awvalid, 1'b0);
        chk1("w1_wvalid_c2", wvalid, 1'b0);
        tick();                                         // cycle 3
        chk1("w1_rsp_valid", rsp_valid, 1'b1);
        chk32("w1_rsp_resp", 32'(rsp_resp), 32'h0);
        chk32("w1_rsp_rdata", rsp_rdata, 32'h0);
        chk1("w1_rsp_timeout", rsp_timeout, 1'b0);
        chk1("w1_bready_c3", bready, 1'b0);
        slave_idle();
        consume("w1");

        // ---- read 0x4, RDATA DEADBEEF ----
        arready = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
        issue(1'b0, 32'h0000_0004, 32'h0, 4'h0);
        tick();                                         // cycle 1
        cmd_valid = 1'b0;
        chk1("r1_arvalid", arvalid, 1'b1);
        chk32("r1_araddr", araddr, 32'h4);
        chk1("r1_rready_c1", rready, 1'b0);
        chk1("r1_awvalid", awvalid, 1'b0);
        tick();                                         // cycle 2
        chk1("r1_rready_c2", rready, 1'b1);
        chk1("r1_arvalid_c2", arvalid, 1'b0);
        tick();                                         // cycle 3
        chk1("r1_rsp_valid", rsp_valid, 1'b1);
        chk32("r1_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk32("r1_rsp_resp", 32'(rsp_resp), 32'h0);
        slave_idle();
        consume("r1");

        // ---- read with DECERR passthrough ----
        arready = 1'b1; rvalid = 1'b1; rdata = 32'hA5A5_0001; rresp = 2'b11;
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk32("r2_rsp_resp", 32'(rsp_resp), 32'h3);
        chk32("r2_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
        slave_idle();
        consume("r2");

        // ---- write 0x8: WREADY immediate, AWREADY after 3 cycles, then SLVERR ----
        wready = 1'b1;
        issue(1'b1, 32'h0000_0008, 32'h0BAD_F00D, 4'h3);
        tick();                                         // cycle 1
        cmd_valid = 1'b0;
        chk1("w2_awvalid_c1", awvalid, 1'b1);
        chk1("w2_wvalid_c1", wvalid, 1'b1);
        tick();                                         // cycle 2
        chk1("w2_wvalid_c2", wvalid, 1'b0);
        chk1("w2_awvalid_c2", awvalid, 1'b1);
        chk32("w2_awaddr_c2", awaddr, 32'h8);
        chk1("w2_bready_c2", bready, 1'b0);
        tick();                                         // cycle 3
        chk1("w2_awvalid_c3", awvalid, 1'b1);
        chk32("w2_awaddr_c3", awaddr, 32'h8);
        tick();                                         // cycle 4
        chk1("w2_awvalid_c4", awvalid, 1'b1);
        chk32("w2_awaddr_c4", awaddr, 32'h8);
        chk1("w2_bready_c4", bready, 1'b0);
        awready = 1'b1;
        tick();                                         // cycle 5
        chk1("w2_awvalid_c5", awvalid, 1'b0);
        chk1("w2_bready_c5", bready, 1'b1);
        awready = 1'b0; wready = 1'b0;
        bvalid = 1'b1; bresp = 2'b10;
        tick();                                         // cycle 6: response
        bvalid = 1'b0; bresp = 2'b00;
        for (int i = 0; i < 5; i++) begin
            chk1("w2_hold_rsp_valid", rsp_valid, 1'b1);
            chk32("w2_hold_rsp_resp", 32'(rsp_resp), 32'h2);
            chk1("w2_hold_rsp_timeout", rsp_timeout, 1'b0);
            chk1("w2_hold_cmd_ready", cmd_ready, 1'b0);
            tick();
        end
        chk1("w2_after_hold_rsp_valid", rsp_valid, 1'b1);
        consume("w2");

        // ---- read timeout: ARREADY never arrives ----
        issue(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        tick();                                         // cycle 1
        cmd_valid = 1'b0;
        chk1("to_arvalid_c1", arvalid, 1'b1);
        for (int i = 2; i <= 16; i++) begin
            tick();
        end                                             // cycle 16
        chk1("to_arvalid_c16", arvalid, 1'b1);
        chk1("to_rsp_valid_c16", rsp_valid, 1'b0);
        tick();                                         // cycle 17
        chk1("to_arvalid_c17", arvalid, 1'b0);
        chk1("to_rready_c17", rready, 1'b0);
        chk1("to_rsp_valid", rsp_valid, 1'b1);
        chk32("to_rsp_resp", 32'(rsp_resp), 32'h2);
        chk1("to_rsp_timeout", rsp_timeout, 1'b1);
        chk32("to_rsp_rdata", rsp_rdata, 32'h0);
        consume("to");

        // ---- ARREADY arriving exactly on the expiry edge ----
        issue(1'b0, 32'h0000_0024, 32'h0, 4'h0);
        tick();                                         // cycle 1
        cmd_valid = 1'b0;
        for (int i = 2; i <= 16; i++) begin
            tick();
        end                                             // cycle 16
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
        tick();                                         // cycle 17
        arready = 1'b0;
        chk1("edge_arvalid_c17", arvalid, 1'b0);
        chk1("edge_rready_c17", rready, 1'b1);
        chk1("edge_rsp_valid_c17", rsp_valid, 1'b0);
        tick();                                         // cycle 18
        chk1("edge_rsp_valid", rsp_valid, 1'b1);
        chk1("edge_rsp_timeout", rsp_timeout, 1'b0);
        chk32("edge_rsp_resp", 32'(rsp_resp), 32'h0);
        chk32("edge_rsp_rdata", rsp_rdata, 32'h1234_5678);
        slave_idle();
        consume("edge");

        // ---- reset during WR_REQ with AWVALID high ----
        issue(1'b1, 32'h0000_0030, 32'h5555_AAAA, 4'hF);
        tick();                                         // cycle 1
        cmd_valid = 1'b0;
        chk1("mr_awvalid_before", awvalid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("mr_awvalid_async", awvalid, 1'b0);
        chk1("mr_wvalid_async", wvalid, 1'b0);
        chk1("mr_cmd_ready_async", cmd_ready, 1'b0);
        chk32("mr_awaddr_async", awaddr, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk1("mr_cmd_ready_after", cmd_ready, 1'b1);
        chk1("mr_no_rsp", rsp_valid, 1'b0);
        arready = 1'b1; rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = 2'b00;
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        tick();
        cmd_valid = 1'b0;
        chk1("mr_rd_arvalid", arvalid, 1'b1);
        tick();
        chk1("mr_rd_rready", rready, 1'b1);
        tick();
        chk1("mr_rd_rsp_valid", rsp_valid, 1'b1);
        chk32("mr_rd_rdata", rsp_rdata, 32'hCAFE_F00D);
        chk1("mr_rd_timeout", rsp_timeout, 1'b0);
        slave_idle();
        consume("mr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
- AXI4-Lite initiator that drives the register slave in neuromorphic_asic_bridge_top (AW/W/B/AR/R) from a simple command/response port.
- Firmware or an on-chip sequencer issues one single-beat register write or read at a time and gets one response per command.
- Includes a per-transaction timeout, so a stalled slave cannot hang the sequencer.

Parameters:
- ADDR_WIDTH, 32, width of the command and AXI address.
- DATA_WIDTH, 32, width of the data path. Strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, bus cycles allowed per transaction. 0 disables the timeout.

Ports:
- clk  in  1  single clock for all logic and the AXI bus.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted on cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed on rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  AXI response code.
- rsp_timeout  out  1  transaction aborted by the timeout.
- M_AXI_AWADDR out ADDR_WIDTH; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
- M_AXI_WDATA out DATA_WIDTH; M_AXI_WSTRB out DATA_WIDTH/8; M_AXI_WVALID out 1; M_AXI_WREADY in 1.
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.
- M_AXI_ARADDR out ADDR_WIDTH; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1.
- M_AXI_RDATA in DATA_WIDTH; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.

Behaviour:
- All outputs are registered.
- While rst is high:
  - state = IDLE.
  - All valid/ready outputs = 0, including cmd_ready.
  - All address, data and response outputs = 0.
  - cmd_ready rises on the first clk edge after rst falls.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - cmd_ready = 1.
  - On accept, latch addr/wdata/wstrb and clear the timeout counter.
  - Go to WR_REQ (cmd_write = 1) or RD_REQ; cmd_ready drops on the same edge.
- WR_REQ:
  - AWVALID and WVALID rise together.
  - Each drops independently on the edge of its own handshake.
  - Leave for WR_RESP when both handshakes are done (same edge or different edges).
  - AWADDR/WDATA/WSTRB stay stable while their valid is high.
- WR_RESP:
  - BREADY = 1.
  - On BVALID: capture BRESP, set rsp_rdata = 0, go to RSP.
- RD_REQ:
  - ARVALID = 1 until the ARREADY handshake, then go to RD_RESP.
- RD_RESP:
  - RREADY = 1.
  - On RVALID: capture RDATA/RRESP, go to RSP.
- RSP:
  - rsp_valid = 1; rsp_rdata/rsp_resp/rsp_timeout held stable until rsp_ready.
  - Then return to IDLE, where cmd_ready = 1 on the next cycle.
- Latency with a zero-wait slave: accept at edge 0, AW/W (or AR) handshake at edge 1, B (or R) handshake at edge 2, rsp_valid high in cycle 3.
- BREADY and RREADY are 0 outside their response states. A late or stray B/R response is not accepted.
- Timeout counter:
  - Width clog2(TIMEOUT_CYCLES+1).
  - Increments each cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - If it reaches TIMEOUT_CYCLES-1 without the completing handshake on that edge: drop all valids/readies, go to RSP with rsp_resp = 2'b10 and rsp_timeout = 1.
  - If a completing handshake and expiry fall on the same edge, the handshake wins: normal response, rsp_timeout = 0.
- BRESP/RRESP are passed through unchanged, including SLVERR and DECERR.
- Reset mid-transaction: all outputs clear immediately (asynchronous) and the transaction is abandoned. No response is produced.
- Only one transaction is outstanding at any time. No pipelining.

Test Plan:
- Write 0x0000 = 0xDEADBEEF, wstrb 0xF, zero-wait slave -> AWVALID and WVALID both high in cycle 1; BREADY in cycle 2; rsp_valid in cycle 3 with rsp_resp 00, rsp_rdata 0, rsp_timeout 0.
- Read 0x0004 with slave RDATA 0xDEADBEEF -> ARVALID in cycle 1, RREADY in cycle 2, rsp_rdata 0xDEADBEEF and rsp_resp 00 in cycle 3.
- Write 0x0008 with WREADY immediate and AWREADY delayed 3 cycles -> WVALID drops after 1 cycle; AWVALID held 4 cycles with AWADDR stable at 0x0008; BREADY only after both handshakes.
- Slave returns BRESP = 2'b10; then hold rsp_ready low for 5 cycles -> rsp_resp 10 and rsp_timeout 0, held stable for 5 cycles; cmd_ready stays 0 until the cycle after rsp_ready.
- TIMEOUT_CYCLES = 16, read with ARREADY held 0 -> ARVALID drops after 16 cycles; next cycle rsp_valid = 1 with rsp_resp 10 and rsp_timeout 1. Repeat with ARREADY arriving exactly on the expiry edge -> normal response.
- Assert rst during WR_REQ with AWVALID high -> all AXI valids and cmd_ready go to 0 without waiting for a clock edge. After release: cmd_ready = 1, and a fresh read completes normally.
